// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: nibble width, nibble type
// and the controller state encoding.
package adder_pkg;

    localparam int NIBBLE_W = 4;

    typedef logic [NIBBLE_W-1:0] nibble_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead slice; c3 is the carry into bit 3, which
// the top level uses with co to derive signed overflow on the last nibble.
module cla4_slice
    import adder_pkg::*;
(
    input  nibble_t a,
    input  nibble_t b,
    input  logic    ci,
    output nibble_t s,
    output logic    c3,
    output logic    co
);

    nibble_t g;
    nibble_t p;
    logic    c1;
    logic    c2;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is expanded directly from generate/propagate terms, not rippled.
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & ci);

    assign s = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle add/subtract unit: one nibble per cycle, LSB first, through a
// single 4-bit lookahead slice, with valid/ready handshakes on both sides.
module nibble_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NUM_NIB = WIDTH / NIBBLE_W;
    localparam int IDXW    = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
    localparam logic [IDXW-1:0] LAST = IDXW'(NUM_NIB - 1);

    state_t           state;
    logic [IDXW-1:0]  idx;
    logic [IDXW+1:0]  base;
    logic             carry;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    nibble_t          na;
    nibble_t          nb;
    nibble_t          ns;
    logic             nc3;
    logic             nco;

    assign in_ready  = (state == IDLE);
    assign busy      = !in_ready;
    assign out_valid = (state == DONE);

    assign base = {idx, 2'b00};
    assign na   = opa[base +: NIBBLE_W];
    assign nb   = opb[base +: NIBBLE_W];

    cla4_slice u_slice (
        .a  (na),
        .b  (nb),
        .ci (carry),
        .s  (ns),
        .c3 (nc3),
        .co (nco)
    );

    // Subtraction is A + ~B + 1, so B is inverted and carry forced to 1 at accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opa   <= a;
                        opb   <= sub ? ~b : b;
                        carry <= sub ? 1'b1 : cin;
                        sum   <= '0;
                        idx   <= '0;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum[base +: NIBBLE_W] <= ns;
                    carry <= nco;
                    idx   <= idx + IDXW'(1);
                    if (idx == LAST) begin
                        cout  <= nco;
                        ovf   <= nc3 ^ nco;
                        idx   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed self-checking bench for nibble_serial_adder at WIDTH=16, with
// hand-computed expected results and fixed-cycle timing checks.
module tb_nibble_serial_adder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    logic        busy;

    int total;
    int passed;
    int failed;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set at a negedge and returns just after the accept edge,
    // scrambling the operand inputs so late changes would corrupt a wrong design.
    task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv,
                                 input logic cv, input logic sv, input string tag);
        @(negedge clk);
        a        = av;
        b        = bv;
        cin      = cv;
        sub      = sv;
        in_valid = 1'b1;
        #1;
        checkOutput({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = ~cv;
        sub      = ~sv;
        checkOutput({tag, ".busy"}, 32'(busy), 32'd1);
    endtask

    // Full operation with out_ready already high: exact 4-cycle latency and a one-cycle DONE.
    task automatic runOp(input logic [15:0] av, input logic [15:0] bv, input logic cv,
                         input logic sv, input logic [15:0] es, input logic ec,
                         input logic eo, input string tag);
        out_ready = 1'b1;
        applyStimulus(av, bv, cv, sv, tag);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".early_valid"}, 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        checkOutput({tag, ".sum"}, 32'(sum), 32'(es));
        checkOutput({tag, ".cout"}, 32'(cout), 32'(ec));
        checkOutput({tag, ".ovf"}, 32'(ovf), 32'(eo));
        @(posedge clk);
        #1;
        checkOutput({tag, ".idle_in_ready"}, 32'(in_ready), 32'd1);
        checkOutput({tag, ".idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        total     = 0;
        passed    = 0;
        failed    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        #1;
        checkOutput("reset.in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset.busy", 32'(busy), 32'd0);
        checkOutput("reset.out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset.sum", 32'(sum), 32'd0);
        checkOutput("reset.cout", 32'(cout), 32'd0);
        checkOutput("reset.ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        runOp(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add");
        runOp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_b");
        runOp(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "ripple_cin");
        runOp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "ovf_pos");
        runOp(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, "ovf_neg");
        runOp(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        runOp(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, "sub_plain");
        runOp(16'hA5A5, 16'h5A5A, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, "add_alt");
        runOp(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        runOp(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, "sub_zero");

        // Backpressure: result held while new operands are offered and must be ignored.
        out_ready = 1'b0;
        applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0, "bp");
        repeat (4) @(posedge clk);
        #1;
        checkOutput("bp.out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        a        = 16'h0100;
        b        = 16'h0200;
        cin      = 1'b0;
        sub      = 1'b0;
        in_valid = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bp.hold_valid", 32'(out_valid), 32'd1);
            checkOutput("bp.hold_sum", 32'(sum), 32'h3333);
            checkOutput("bp.hold_cout", 32'(cout), 32'd0);
            checkOutput("bp.hold_ovf", 32'(ovf), 32'd0);
            checkOutput("bp.hold_in_ready", 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp.release_in_ready", 32'(in_ready), 32'd1);
        checkOutput("bp.release_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("bp.next_busy", 32'(busy), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
            checkOutput("bp.next_early_valid", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput("bp.next_valid", 32'(out_valid), 32'd1);
        checkOutput("bp.next_sum", 32'(sum), 32'h0300);
        @(posedge clk);
        #1;
        checkOutput("bp.next_idle", 32'(in_ready), 32'd1);

        // Reset arrives with the index at 2; the aborted operation never completes.
        applyStimulus(16'h1234, 16'h1111, 1'b0, 1'b0, "rst");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.sum", 32'(sum), 32'd0);
        checkOutput("rst.cout", 32'(cout), 32'd0);
        checkOutput("rst.ovf", 32'(ovf), 32'd0);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst.busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
            checkOutput("rst.no_valid", 32'(out_valid), 32'd0);
        end
        checkOutput("rst.after_in_ready", 32'(in_ready), 32'd1);
        runOp(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
